// File: rtl/spi_reg_bank_if.sv
// SPI pin bundle between the external controller and the register bank.
// All three lines are asynchronous to the system clock at the target side.
interface spi_reg_bank_if;
    logic sclk;
    logic copi;
    logic ncs;

    modport master (output sclk, output copi, output ncs);
    modport slave  (input  sclk, input  copi, input  ncs);
endinterface

// File: rtl/spi_reg_bank.sv
// Write-only mode-0 SPI target holding the five PWM configuration registers.
// SPI pins are oversampled on clk; nothing is clocked by SCLK.
module spi_reg_bank #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [6:0]  MAX_ADDR    = 7'h04
) (
    input  logic               clk,
    input  logic               rst,
    spi_reg_bank_if.slave      spi,
    output logic [7:0]         en_reg_out_7_0,
    output logic [7:0]         en_reg_out_15_8,
    output logic [7:0]         en_reg_pwm_7_0,
    output logic [7:0]         en_reg_pwm_15_8,
    output logic [7:0]         pwm_duty_cycle,
    output logic               wr_strobe
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] copi_sync_q;
    logic [SYNC_STAGES-1:0] ncs_sync_q;
    logic [SYNC_STAGES-1:0] ncs_valid_q;
    logic                   sclk_hist_q;
    logic                   ncs_hist_q;
    logic                   ncs_armed_q;

    logic                   sclk_s;
    logic                   copi_s;
    logic                   ncs_s;
    logic                   sclk_rise;
    logic                   ncs_fall;
    logic                   ncs_rise;

    state_e                 state_q;
    logic [4:0]             cnt_q;
    logic [15:0]            shreg_q;
    logic                   wr_strobe_q;
    logic [7:0]             reg0_q;
    logic [7:0]             reg1_q;
    logic [7:0]             reg2_q;
    logic [7:0]             reg3_q;
    logic [7:0]             reg4_q;

    logic [6:0]             frame_addr;
    logic [7:0]             frame_data;
    logic                   frame_ok;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign copi_s = copi_sync_q[SYNC_STAGES-1];
    assign ncs_s  = ncs_sync_q[SYNC_STAGES-1];

    // ncs_valid_q marks when the ncs pipeline holds pin samples rather than
    // reset fill; a frame may only start once ncs has been seen high from the pin,
    // so an ncs already low when reset is released cannot open a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            copi_sync_q <= '0;
            ncs_sync_q  <= '1;
            ncs_valid_q <= '0;
            sclk_hist_q <= 1'b0;
            ncs_hist_q  <= 1'b1;
            ncs_armed_q <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk};
            copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], spi.copi};
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], spi.ncs};
            ncs_valid_q <= {ncs_valid_q[SYNC_STAGES-2:0], 1'b1};
            sclk_hist_q <= sclk_s;
            ncs_hist_q  <= ncs_s;
            if (ncs_valid_q[SYNC_STAGES-1] && ncs_s) begin
                ncs_armed_q <= 1'b1;
            end
        end
    end

    assign sclk_rise = sclk_s & ~sclk_hist_q;
    assign ncs_fall  = ~ncs_s & ncs_hist_q & ncs_armed_q;
    assign ncs_rise  = ncs_s & ~ncs_hist_q;

    assign frame_addr = shreg_q[14:8];
    assign frame_data = shreg_q[7:0];
    assign frame_ok   = (cnt_q == 5'd16) && shreg_q[15] && (frame_addr <= MAX_ADDR);

    // ncs_rise is tested before sclk_rise so a coincident clock edge is dropped
    // and the commit sees the pre-edge bit count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            wr_strobe_q <= 1'b0;
            reg0_q      <= '0;
            reg1_q      <= '0;
            reg2_q      <= '0;
            reg3_q      <= '0;
            reg4_q      <= '0;
        end else begin
            wr_strobe_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ncs_fall) begin
                        state_q <= SHIFT;
                        cnt_q   <= '0;
                        shreg_q <= '0;
                    end
                end
                SHIFT: begin
                    if (ncs_rise) begin
                        state_q <= IDLE;
                        if (frame_ok) begin
                            wr_strobe_q <= 1'b1;
                            case (frame_addr)
                                7'h00:   reg0_q <= frame_data;
                                7'h01:   reg1_q <= frame_data;
                                7'h02:   reg2_q <= frame_data;
                                7'h03:   reg3_q <= frame_data;
                                7'h04:   reg4_q <= frame_data;
                                default: ;
                            endcase
                        end
                    end else if (sclk_rise) begin
                        shreg_q <= {shreg_q[14:0], copi_s};
                        if (cnt_q != 5'd17) begin
                            cnt_q <= cnt_q + 5'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign en_reg_out_7_0  = reg0_q;
    assign en_reg_out_15_8 = reg1_q;
    assign en_reg_pwm_7_0  = reg2_q;
    assign en_reg_pwm_15_8 = reg3_q;
    assign pwm_duty_cycle  = reg4_q;
    assign wr_strobe       = wr_strobe_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: bit-banged SPI frames, immediate-assert checks.
module tb_spi_reg_bank;

    logic       clk;
    logic       rst;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       wr_strobe;

    int compared;
    int mismatched;
    int strobe_cnt;
    int s0;
    time rise_t;
    int  lat_arr [64];
    logic [39:0] snap_arr [64];

    spi_reg_bank_if spi ();

    spi_reg_bank #(
        .SYNC_STAGES (2),
        .MAX_ADDR    (7'h04)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .spi             (spi),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .wr_strobe       (wr_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe monitor: latency from the ncs rise and a snapshot of all registers.
    always @(negedge clk) begin
        if (wr_strobe === 1'b1) begin
            if (strobe_cnt < 64) begin
                lat_arr[strobe_cnt]  = int'(($time - rise_t) / 10);
                snap_arr[strobe_cnt] = {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0,
                                        en_reg_out_15_8, en_reg_out_7_0};
            end
            strobe_cnt = strobe_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared = compared + 1;
        assert (obs === exp) else begin
            mismatched = mismatched + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic frame_begin();
        spi.ncs = 1'b0;
        cycles(2);
    endtask

    task automatic shift_bits(input logic [16:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            spi.copi = val[i];
            cycles(2);
            spi.sclk = 1'b1;
            cycles(2);
            spi.sclk = 1'b0;
        end
    endtask

    task automatic frame_end(input int gap);
        cycles(2);
        spi.ncs = 1'b1;
        rise_t  = $time;
        cycles(gap);
    endtask

    task automatic send(input logic [16:0] val, input int n, input int gap);
        frame_begin();
        shift_bits(val, n);
        frame_end(gap);
    endtask

    initial begin
        logic [15:0] b2b [5];
        compared   = 0;
        mismatched = 0;
        strobe_cnt = 0;
        rise_t     = 0;
        rst        = 1'b1;
        spi.sclk   = 1'b0;
        spi.copi   = 1'b0;
        spi.ncs    = 1'b1;
        cycles(3);

        check("rst_out_lo",  {24'h0, en_reg_out_7_0},  32'h00);
        check("rst_out_hi",  {24'h0, en_reg_out_15_8}, 32'h00);
        check("rst_pwm_lo",  {24'h0, en_reg_pwm_7_0},  32'h00);
        check("rst_pwm_hi",  {24'h0, en_reg_pwm_15_8}, 32'h00);
        check("rst_duty",    {24'h0, pwm_duty_cycle},  32'h00);
        check("rst_strobe",  {31'h0, wr_strobe},       32'h0);

        rst = 1'b0;
        cycles(4);

        s0 = strobe_cnt;
        send(17'h08055, 16, 6);
        check("first_write", {24'h0, en_reg_out_7_0}, 32'h55);
        check("first_strobes", strobe_cnt - s0, 1);

        s0 = strobe_cnt;
        send(17'h080AA, 16, 6);
        send(17'h081BB, 16, 6);
        send(17'h082CC, 16, 6);
        send(17'h083DD, 16, 6);
        send(17'h08480, 16, 6);
        check("addr0", {24'h0, en_reg_out_7_0},  32'hAA);
        check("addr1", {24'h0, en_reg_out_15_8}, 32'hBB);
        check("addr2", {24'h0, en_reg_pwm_7_0},  32'hCC);
        check("addr3", {24'h0, en_reg_pwm_15_8}, 32'hDD);
        check("addr4", {24'h0, pwm_duty_cycle},  32'h80);
        check("addr_strobes", strobe_cnt - s0, 5);

        s0 = strobe_cnt;
        send(17'h08512, 16, 6);
        check("bad_addr_duty", {24'h0, pwm_duty_cycle}, 32'h80);
        send(17'h00412, 16, 6);
        check("read_duty", {24'h0, pwm_duty_cycle}, 32'h80);
        check("reject_out_lo", {24'h0, en_reg_out_7_0}, 32'hAA);
        check("reject_strobes", strobe_cnt - s0, 0);

        s0 = strobe_cnt;
        send(17'h04108, 15, 6);
        check("short_pwm_lo", {24'h0, en_reg_pwm_7_0}, 32'hCC);
        send(17'h10422, 17, 6);
        check("long_pwm_lo", {24'h0, en_reg_pwm_7_0}, 32'hCC);
        check("count_err_strobes", strobe_cnt - s0, 0);
        send(17'h08203, 16, 6);
        check("recover_pwm_lo", {24'h0, en_reg_pwm_7_0}, 32'h03);
        check("recover_strobes", strobe_cnt - s0, 1);

        send(17'h08440, 16, 6);
        check("preset_duty", {24'h0, pwm_duty_cycle}, 32'h40);
        frame_begin();
        shift_bits(17'h00084, 8);
        rst = 1'b1;
        cycles(2);
        check("midrst_duty", {24'h0, pwm_duty_cycle}, 32'h00);
        check("midrst_out_lo", {24'h0, en_reg_out_7_0}, 32'h00);
        rst = 1'b0;
        s0 = strobe_cnt;
        shift_bits(17'h000FF, 8);
        frame_end(6);
        check("midrst_after_duty", {24'h0, pwm_duty_cycle}, 32'h00);
        check("midrst_strobes", strobe_cnt - s0, 0);
        send(17'h084FF, 16, 6);
        check("post_rst_duty", {24'h0, pwm_duty_cycle}, 32'hFF);
        check("post_rst_strobes", strobe_cnt - s0, 1);

        b2b[0] = 16'h8011;
        b2b[1] = 16'h8122;
        b2b[2] = 16'h8233;
        b2b[3] = 16'h8344;
        b2b[4] = 16'h8455;
        s0 = strobe_cnt;
        for (int f = 0; f < 5; f++) begin
            send({1'b0, b2b[f]}, 16, 2);
        end
        cycles(8);
        check("b2b_strobes", strobe_cnt - s0, 5);
        for (int f = 0; f < 5; f++) begin
            logic [39:0] snap;
            logic [7:0]  got;
            int          a;
            int          lat;
            a    = int'(b2b[f][10:8]);
            snap = (s0 + f < 64) ? snap_arr[s0 + f] : 40'h0;
            lat  = (s0 + f < 64) ? lat_arr[s0 + f] : 99;
            got  = snap[a*8 +: 8];
            check($sformatf("b2b_val%0d", f), {24'h0, got}, {24'h0, b2b[f][7:0]});
            check($sformatf("b2b_lat%0d", f), {31'h0, (lat >= 1 && lat <= 4)}, 32'h1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
